// File: rtl/fp16_pkg.sv
// fp16_pkg: shared widths, limits, normalizer state and exception status codes
package fp16_pkg;
  localparam int EXP_W = 5;
  localparam int MANT_W = 10;
  localparam int EXP_MAX = 31;
  localparam int EXP_UFLOW = 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} norm_state_t;
  typedef enum logic [1:0] {ST_ZERO = 2'b00, ST_OVFL = 2'b01, ST_UFLOW = 2'b10, ST_NORM = 2'b11} norm_status_t;
endpackage

// File: rtl/fp16_normalize.sv
// fp16_normalize: iterative one-bit-per-cycle left-shift normalizer with valid/ready handshake
module fp16_normalize import fp16_pkg::*; #(
  parameter int EXP_W = fp16_pkg::EXP_W,
  parameter int MANT_W = fp16_pkg::MANT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W+1:0] mant_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sr1d,
  output logic [EXP_W-1:0]  ed,
  output logic [MANT_W:0]   mnd
);
  localparam logic [EXP_W-1:0] UFLOW = EXP_W'(EXP_UFLOW);
  norm_state_t state_q;
  logic sr1d_q;
  logic [EXP_W-1:0] ed_q, ed_d;
  logic [MANT_W:0] mnd_q, mnd_d;
  assign mnd_d = {mnd_q[MANT_W-1:0], 1'b0};
  assign ed_d = ed_q - 1'b1;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sr1d = sr1d_q;
  assign ed = ed_q;
  assign mnd = mnd_q;
  // SHIFT looks ahead at the shifted value so k shifts cost exactly k cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr1d_q <= 1'b0;
      ed_q <= '0;
      mnd_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sr1d_q <= sign_in;
          state_q <= DONE;
          if (mant_in == '0) begin
            ed_q <= '0;
            mnd_q <= '0;
          end else if (&exp_in) begin
            ed_q <= exp_in;
            mnd_q <= mant_in[MANT_W:0];
          end else if (mant_in[MANT_W+1]) begin
            ed_q <= exp_in + 1'b1;
            mnd_q <= mant_in[MANT_W+1:1];
          end else if (mant_in[MANT_W]) begin
            ed_q <= exp_in;
            mnd_q <= mant_in[MANT_W:0];
          end else if (exp_in <= UFLOW) begin
            ed_q <= UFLOW;
            mnd_q <= mant_in[MANT_W:0];
          end else begin
            ed_q <= exp_in;
            mnd_q <= mant_in[MANT_W:0];
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          mnd_q <= mnd_d;
          ed_q <= ed_d;
          if (mnd_d[MANT_W] || ed_d <= UFLOW) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_normalize.sv
// tb_fp16_normalize: directed vectors with hand-computed results, latency and backpressure checks
module tb_fp16_normalize;
  logic clk = 0, rst = 1, in_valid = 0, sign_in = 0, out_ready = 0;
  logic [4:0] exp_in = '0;
  logic [11:0] mant_in = '0;
  logic in_ready, out_valid, sr1d;
  logic [4:0] ed;
  logic [10:0] mnd;
  int nvec = 0, nerr = 0;

  fp16_normalize dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sr1d(sr1d), .ed(ed), .mnd(mnd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s; logic [4:0] e; logic [11:0] m;
    logic [4:0] xe; logic [10:0] xm; int lat; int hold;
  } vec_t;

  vec_t vecs[12] = '{
    '{1'b1, 5'd15, 12'hC00, 5'd16, 11'h600, 1, 0},
    '{1'b0, 5'd10, 12'h5A5, 5'd10, 11'h5A5, 1, 0},
    '{1'b0, 5'd20, 12'h0F0, 5'd17, 11'h780, 4, 5},
    '{1'b0, 5'd3,  12'h001, 5'd1,  11'h004, 3, 0},
    '{1'b1, 5'd12, 12'h000, 5'd0,  11'h000, 1, 2},
    '{1'b0, 5'd30, 12'h800, 5'd31, 11'h400, 1, 0},
    '{1'b0, 5'd31, 12'h0F0, 5'd31, 11'h0F0, 1, 0},
    '{1'b0, 5'd5,  12'h001, 5'd1,  11'h010, 5, 0},
    '{1'b1, 5'd20, 12'h001, 5'd10, 11'h400, 11, 1},
    '{1'b1, 5'd31, 12'hFFF, 5'd31, 11'h7FF, 1, 0},
    '{1'b0, 5'd0,  12'h200, 5'd1,  11'h200, -1, 0},
    '{1'b0, 5'd29, 12'hFFF, 5'd30, 11'h7FF, 1, 0}
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic s, input logic [4:0] e, input logic [11:0] m);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    sign_in = s; exp_in = e; mant_in = m; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid) chk("busy_in_ready", 32'(in_ready), 32'd0);
    end while (!out_valid && n < 20);
    chk("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ed", 32'(ed), 32'd0);
    chk("rst_mnd", 32'(mnd), 32'd0);
    chk("rst_sr1d", 32'(sr1d), 32'd0);

    foreach (vecs[i]) begin
      send(vecs[i].s, vecs[i].e, vecs[i].m);
      wait_out(n);
      if (vecs[i].lat >= 0) chk($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].lat));
      chk($sformatf("v%0d_ed", i), 32'(ed), 32'(vecs[i].xe));
      chk($sformatf("v%0d_mnd", i), 32'(mnd), 32'(vecs[i].xm));
      chk($sformatf("v%0d_sr1d", i), 32'(sr1d), 32'(vecs[i].s));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd0);
      for (int h = 0; h < vecs[i].hold; h++) begin
        @(negedge clk);
        chk($sformatf("v%0d_hold_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_hold_ready", i), 32'(in_ready), 32'd0);
        chk($sformatf("v%0d_hold_ed", i), 32'(ed), 32'(vecs[i].xe));
        chk($sformatf("v%0d_hold_mnd", i), 32'(mnd), 32'(vecs[i].xm));
      end
      out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_valid_drop", i), 32'(out_valid), 32'd0);
    end

    send(1'b1, 5'd20, 12'h001);
    repeat (3) @(negedge clk);
    chk("mid_shift_busy", 32'(in_ready), 32'd0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_ed", 32'(ed), 32'd0);
    chk("abort_mnd", 32'(mnd), 32'd0);
    chk("abort_sr1d", 32'(sr1d), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fp16_normalize.md
# fp16_normalize

Iterative post-operation normalizer for the 16-bit floating-point ALU datapath. It takes the raw sign, exponent and 12-bit mantissa from the add/sub and multiply stages. It produces a normalized 5-bit exponent and an 11-bit mantissa with the hidden bit set, and feeds the exception-check stage (`sr1d`, `ed`, `mnd`). A valid/ready handshake brackets a multi-cycle left-shift loop.

## Interface
Parameters:
- `EXP_W`, 5, exponent width
- `MANT_W`, 10, stored fraction width (internal mantissa is `MANT_W+2`)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input operand valid
- `in_ready`  out  1  block can accept; high only in IDLE
- `sign_in`  in  1  result sign from arithmetic stage
- `exp_in`  in  5  unnormalized exponent
- `mant_in`  in  12  bit 11 = carry-out, bit 10 = hidden-bit position
- `out_valid`  out  1  normalized result valid
- `out_ready`  in  1  downstream accepts
- `sr1d`  out  1  registered sign
- `ed`  out  5  normalized exponent
- `mnd`  out  11  normalized mantissa, bit 10 = hidden bit

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: `in_ready`=1. On `in_valid`, capture the inputs and decide the next state on the captured value:
  - `mant_in`==0: result `ed`=0, `mnd`=0; go to DONE.
  - `exp_in`==31: `ed`=31, `mnd`=`mant_in[10:0]`; go to DONE. The overflow is passed through.
  - `mant_in[11]`=1: `mnd`=`mant_in[11:1]` (truncate, no rounding).
    - `ed` = `exp_in`+1, saturating at 31, so `exp_in`≥30 gives 31.
    - Go to DONE.
  - `mant_in[10]`=1: `mnd`=`mant_in[10:0]`, `ed`=`exp_in`; go to DONE.
  - Otherwise: go to SHIFT.
- SHIFT, one bit per cycle:
  - If `mnd[10]`=1 or `ed`≤1, go to DONE.
  - Otherwise shift `mnd` left by 1 with zero fill, decrement `ed`, and stay in SHIFT.
  - `ed` never goes below 1. If it would, it is forced to 1 on exit: `exp_in`=0 with a nonzero mantissa exits with `ed`=1. This is the underflow marker for the downstream stage.
- DONE: `out_valid`=1 and the outputs are held stable. On `out_ready`, go to IDLE. No new input is accepted until then.
- At most 10 SHIFT iterations (mantissa bit 0 reaching bit 10).
- `sr1d` is the captured `sign_in`, unchanged by normalization.

## Timing
- Reset (sync):
  - State = IDLE.
  - `out_valid`=0, `sr1d`=0, `ed`=0, `mnd`=0.
  - `in_ready`=1 from the first cycle after reset.
- Accept cycle T (`in_valid`&`in_ready`). Non-shift cases: `out_valid`=1 at T+1.
- k left shifts needed: k SHIFT cycles, then the exit check cycle. `out_valid`=1 at T+1+k.
- `out_valid` and outputs are held while `out_ready`=0. The transfer occurs on the edge where `out_valid`&`out_ready`.
- Earliest next accept is the cycle after the transfer, when IDLE is re-entered. No bypass.
- `rst` asserted in any state aborts the operation; the reset values apply at the next edge.
- `in_valid` is ignored outside IDLE; the upstream stage must hold its data.

## Structure
- Shared package `fp16_pkg`:
  - `EXP_W`=5, `MANT_W`=10
  - `EXP_MAX`=31, `EXP_UFLOW`=1
  - State enum `norm_state_t` {IDLE, SHIFT, DONE}
  - Status codes shared with the exception check: 00 zero, 01 overflow, 10 underflow, 11 normal
- Single module; no sub-module. The one-bit-per-cycle loop replaces a leading-zero counter.

## Test plan
- Carry: `exp_in`=15, `mant_in`=12'hC00, sign 1 -> T+1: `ed`=16, `mnd`=11'h600, `sr1d`=1.
- Already normalized: `exp_in`=10, `mant_in`=12'h5A5 -> T+1: `ed`=10, `mnd`=11'h5A5.
- Three shifts: `exp_in`=20, `mant_in`=12'h0F0 -> `out_valid` at T+4, `ed`=17, `mnd`=11'h780; `in_ready`=0 during T+1..T+4.
- Underflow floor: `exp_in`=3, `mant_in`=12'h001 -> `ed`=1, `mnd`=11'h004, `out_valid` at T+3.
- Zero and saturation:
  - `mant_in`=0, `exp_in`=12 -> `ed`=0, `mnd`=0 at T+1.
  - `exp_in`=30, `mant_in`=12'h800 -> `ed`=31, `mnd`=11'h400.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles in DONE: outputs stable and `in_ready`=0 throughout.
  - Assert `rst` mid-SHIFT: next cycle IDLE, `out_valid`=0, all outputs 0.
